execute_stage: RTL and testbench

//  X stage of the 16-bit five-stage pipeline; consumes the decode/execute register outputs.

---
 rtl/execute_stage.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_execute_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute stage of the 16-bit five-stage pipeline: operand forwarding,
// ALU/address/immediate ops, Z/V/N flag register and the X/M output register.
//
// Optional feature: define FORWARDING_EN to select operands from the X/M and
// M/W producers; without it opA=a, opB=b and hazards are resolved by stalls.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   wen, flush         advance enable (0 = stall), bubble insert when advancing
//   ALUsrc..LoadPartial D/X control bits, captured into xm_*_out
//   instruction        [15:12] opcode, [3:0] shift amount
//   a, b, imm, newPC   register operands, sign-extended immediate, PC+2
//   reg_dest, Source1, Source2  destination and source register numbers
//   mem_fwd_*, wb_fwd_* forwarding producers (X/M has priority over M/W)
//   xm_*               registered execute/memory outputs
//   flags              {Z,V,N}
module execute_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic             flush,
    input  logic             ALUsrc,
    input  logic             MemtoReg,
    input  logic             RegWrite,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             SavePC,
    input  logic             halt,
    input  logic             LoadPartial,
    input  logic [WIDTH-1:0] instruction,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] newPC,
    input  logic [3:0]       reg_dest,
    input  logic [3:0]       Source1,
    input  logic [3:0]       Source2,
    input  logic             mem_fwd_we,
    input  logic [3:0]       mem_fwd_reg,
    input  logic [WIDTH-1:0] mem_fwd_data,
    input  logic             wb_fwd_we,
    input  logic [3:0]       wb_fwd_reg,
    input  logic [WIDTH-1:0] wb_fwd_data,
    output logic             xm_alusrc_out,
    output logic             xm_memtoreg_out,
    output logic             xm_regwrite_out,
    output logic             xm_memread_out,
    output logic             xm_memwrite_out,
    output logic             xm_savepc_out,
    output logic             xm_halt_out,
    output logic             xm_loadpartial_out,
    output logic [WIDTH-1:0] xm_result,
    output logic [WIDTH-1:0] xm_store,
    output logic [3:0]       xm_dest,
    output logic [WIDTH-1:0] xm_inst,
    output logic [2:0]       flags
);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_XOR = 4'h2;
    localparam logic [3:0] OP_RED = 4'h3;
    localparam logic [3:0] OP_SLL = 4'h4;
    localparam logic [3:0] OP_SRA = 4'h5;
    localparam logic [3:0] OP_ROR = 4'h6;
    localparam logic [3:0] OP_PAD = 4'h7;
    localparam logic [3:0] OP_LW  = 4'h8;
    localparam logic [3:0] OP_SW  = 4'h9;
    localparam logic [3:0] OP_LLB = 4'hA;
    localparam logic [3:0] OP_LHB = 4'hB;
    localparam logic [3:0] OP_PCS = 4'hE;

    logic [15:0] opa;
    logic [15:0] opb;

`ifdef FORWARDING_EN
    always_comb begin
        opa = a;
        if (mem_fwd_we && mem_fwd_reg == Source1 && Source1 != 4'd0)
            opa = mem_fwd_data;
        else if (wb_fwd_we && wb_fwd_reg == Source1 && Source1 != 4'd0)
            opa = wb_fwd_data;
    end

    always_comb begin
        opb = b;
        if (mem_fwd_we && mem_fwd_reg == Source2 && Source2 != 4'd0)
            opb = mem_fwd_data;
        else if (wb_fwd_we && wb_fwd_reg == Source2 && Source2 != 4'd0)
            opb = wb_fwd_data;
    end
`else
    assign opa = a;
    assign opb = b;

    logic unused_fwd;
    assign unused_fwd = ^{Source1, Source2, mem_fwd_we, mem_fwd_reg,
                          mem_fwd_data, wb_fwd_we, wb_fwd_reg, wb_fwd_data};
`endif

    logic unused_inst;
    assign unused_inst = ^instruction[11:4];

    // Signed 4-bit add clamped to 7 / -8.
    function automatic logic [3:0] sat4(input logic [3:0] x, input logic [3:0] y);
        logic [4:0] s;
        s = {x[3], x} + {y[3], y};
        if (s[4] != s[3])
            return s[4] ? 4'h8 : 4'h7;
        return s[3:0];
    endfunction

    logic [3:0]  opcode;
    logic [3:0]  shamt;
    logic [15:0] alub;
    logic [15:0] sum;
    logic [15:0] diff;
    logic        add_ovf;
    logic        sub_ovf;
    logic [15:0] sat_val;
    logic [9:0]  red;
    logic [31:0] rot;
    logic [15:0] res;
    logic        upd_all;
    logic        upd_z;
    logic        ovf;

    assign opcode  = instruction[15:12];
    assign shamt   = instruction[3:0];
    assign alub    = ALUsrc ? imm : opb;
    assign sum     = opa + alub;
    assign diff    = opa - alub;
    assign add_ovf = (opa[15] == alub[15]) && (sum[15] != opa[15]);
    assign sub_ovf = (opa[15] != alub[15]) && (diff[15] != opa[15]);
    assign sat_val = opa[15] ? 16'h8000 : 16'h7FFF;
    assign red     = {{2{opa[15]}}, opa[15:8]} + {{2{opa[7]}}, opa[7:0]}
                   + {{2{alub[15]}}, alub[15:8]} + {{2{alub[7]}}, alub[7:0]};
    assign rot     = {opa, opa} >> shamt;

    always_comb begin
        res     = 16'h0000;
        upd_all = 1'b0;
        upd_z   = 1'b0;
        ovf     = 1'b0;
        case (opcode)
            OP_ADD: begin
                res     = add_ovf ? sat_val : sum;
                ovf     = add_ovf;
                upd_all = 1'b1;
            end
            OP_SUB: begin
                res     = sub_ovf ? sat_val : diff;
                ovf     = sub_ovf;
                upd_all = 1'b1;
            end
            OP_XOR: begin
                res   = opa ^ alub;
                upd_z = 1'b1;
            end
            OP_RED: res = {{6{red[9]}}, red};
            OP_SLL: begin
                res   = opa << shamt;
                upd_z = 1'b1;
            end
            OP_SRA: begin
                res   = 16'($signed(opa) >>> shamt);
                upd_z = 1'b1;
            end
            OP_ROR: begin
                res   = rot[15:0];
                upd_z = 1'b1;
            end
            OP_PAD: res = {sat4(opa[15:12], alub[15:12]),
                           sat4(opa[11:8], alub[11:8]),
                           sat4(opa[7:4], alub[7:4]),
                           sat4(opa[3:0], alub[3:0])};
            OP_LW, OP_SW: res = (opa & 16'hFFFE) + imm;
            OP_LLB: res = (opa & 16'hFF00) | {8'h00, imm[7:0]};
            OP_LHB: res = (opa & 16'h00FF) | {imm[7:0], 8'h00};
            OP_PCS: res = newPC;
            default: res = 16'h0000;
        endcase
    end

    logic [2:0] flags_q, flags_d;
    logic       flag_en;

    // Bubbles carry neither RegWrite nor halt and must not touch flags.
    assign flag_en = wen && !flush && (RegWrite || halt);

    always_comb begin
        flags_d = flags_q;
        if (upd_all)
            flags_d = {res == 16'h0000, ovf, res[15]};
        else if (upd_z)
            flags_d[2] = (res == 16'h0000);
    end

    logic        alusrc_q, alusrc_d;
    logic        memtoreg_q, memtoreg_d;
    logic        regwrite_q, regwrite_d;
    logic        memread_q, memread_d;
    logic        memwrite_q, memwrite_d;
    logic        savepc_q, savepc_d;
    logic        halt_q, halt_d;
    logic        lpart_q, lpart_d;
    logic [15:0] result_q, result_d;
    logic [15:0] store_q, store_d;
    logic [3:0]  dest_q, dest_d;
    logic [15:0] inst_q, inst_d;

    // A latched halt keeps asserting itself and suppresses any
    // architectural side effect of instructions that trail it.
    always_comb begin
        alusrc_d   = ALUsrc;
        memtoreg_d = MemtoReg;
        regwrite_d = RegWrite && !halt_q;
        memread_d  = MemRead && !halt_q;
        memwrite_d = MemWrite && !halt_q;
        savepc_d   = SavePC;
        halt_d     = halt || halt_q;
        lpart_d    = LoadPartial;
        result_d   = res;
        store_d    = opb;
        dest_d     = reg_dest;
        inst_d     = instruction;
        if (flush) begin
            alusrc_d   = 1'b0;
            memtoreg_d = 1'b0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            savepc_d   = 1'b0;
            halt_d     = 1'b0;
            lpart_d    = 1'b0;
            result_d   = 16'h0000;
            store_d    = 16'h0000;
            dest_d     = 4'h0;
            inst_d     = 16'h0000;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alusrc_q   <= 1'b0;
            memtoreg_q <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            savepc_q   <= 1'b0;
            halt_q     <= 1'b0;
            lpart_q    <= 1'b0;
            result_q   <= 16'h0000;
            store_q    <= 16'h0000;
            dest_q     <= 4'h0;
            inst_q     <= 16'h0000;
        end else if (wen) begin
            alusrc_q   <= alusrc_d;
            memtoreg_q <= memtoreg_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            savepc_q   <= savepc_d;
            halt_q     <= halt_d;
            lpart_q    <= lpart_d;
            result_q   <= result_d;
            store_q    <= store_d;
            dest_q     <= dest_d;
            inst_q     <= inst_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flags_q <= 3'b000;
        else if (flag_en)
            flags_q <= flags_d;
    end

    assign xm_alusrc_out      = alusrc_q;
    assign xm_memtoreg_out    = memtoreg_q;
    assign xm_regwrite_out    = regwrite_q;
    assign xm_memread_out     = memread_q;
    assign xm_memwrite_out    = memwrite_q;
    assign xm_savepc_out      = savepc_q;
    assign xm_halt_out        = halt_q;
    assign xm_loadpartial_out = lpart_q;
    assign xm_result          = result_q;
    assign xm_store           = store_q;
    assign xm_dest            = dest_q;
    assign xm_inst            = inst_q;
    assign flags              = flags_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed testbench for execute_stage.
// Flags are {Z,V,N}; expected values are hand-computed constants.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wen = 1'b1;
    logic        flush = 1'b0;
    logic        ALUsrc = 1'b0, MemtoReg = 1'b0, RegWrite = 1'b0;
    logic        MemRead = 1'b0, MemWrite = 1'b0, SavePC = 1'b0;
    logic        halt = 1'b0, LoadPartial = 1'b0;
    logic [15:0] instruction = '0, a = '0, b = '0, imm = '0, newPC = '0;
    logic [3:0]  reg_dest = '0, Source1 = '0, Source2 = '0;
    logic        mem_fwd_we = 1'b0, wb_fwd_we = 1'b0;
    logic [3:0]  mem_fwd_reg = '0, wb_fwd_reg = '0;
    logic [15:0] mem_fwd_data = '0, wb_fwd_data = '0;

    logic        xm_alusrc_out, xm_memtoreg_out, xm_regwrite_out;
    logic        xm_memread_out, xm_memwrite_out, xm_savepc_out;
    logic        xm_halt_out, xm_loadpartial_out;
    logic [15:0] xm_result, xm_store, xm_inst;
    logic [3:0]  xm_dest;
    logic [2:0]  flags;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk(clk), .rst(rst), .wen(wen), .flush(flush),
        .ALUsrc(ALUsrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .SavePC(SavePC),
        .halt(halt), .LoadPartial(LoadPartial),
        .instruction(instruction), .a(a), .b(b), .imm(imm), .newPC(newPC),
        .reg_dest(reg_dest), .Source1(Source1), .Source2(Source2),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_reg(mem_fwd_reg),
        .mem_fwd_data(mem_fwd_data),
        .wb_fwd_we(wb_fwd_we), .wb_fwd_reg(wb_fwd_reg),
        .wb_fwd_data(wb_fwd_data),
        .xm_alusrc_out(xm_alusrc_out), .xm_memtoreg_out(xm_memtoreg_out),
        .xm_regwrite_out(xm_regwrite_out), .xm_memread_out(xm_memread_out),
        .xm_memwrite_out(xm_memwrite_out), .xm_savepc_out(xm_savepc_out),
        .xm_halt_out(xm_halt_out), .xm_loadpartial_out(xm_loadpartial_out),
        .xm_result(xm_result), .xm_store(xm_store), .xm_dest(xm_dest),
        .xm_inst(xm_inst), .flags(flags)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Present one ALU-type instruction and advance one clock.
    task automatic issue(input logic [15:0] inst, input logic [15:0] av,
                         input logic [15:0] bv, input logic [15:0] iv,
                         input logic src);
        instruction = inst;
        a = av;
        b = bv;
        imm = iv;
        ALUsrc = src;
        RegWrite = 1'b1;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        halt = 1'b0;
        wen = 1'b1;
        flush = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] fwd_exp1, fwd_exp2;

    initial begin
`ifdef FORWARDING_EN
        fwd_exp1 = 16'h1112;
        fwd_exp2 = 16'h2223;
`else
        fwd_exp1 = 16'h0001;
        fwd_exp2 = 16'h0001;
`endif
        #12;
        chk("reset_result", xm_result, 16'h0000);
        chk("reset_flags", {13'd0, flags}, 16'h0000);
        chk("reset_halt", {15'd0, xm_halt_out}, 16'h0000);
        rst = 1'b0;

        issue(16'h0000, 16'h7FF0, 16'h0020, 16'h0000, 1'b0);
        chk("add_sat", xm_result, 16'h7FFF);
        chk("add_flags", {13'd0, flags}, 16'h0002);
        chk("add_rw", {15'd0, xm_regwrite_out}, 16'h0001);

        issue(16'h1000, 16'h0005, 16'h0005, 16'h0000, 1'b0);
        chk("sub_zero", xm_result, 16'h0000);
        chk("sub_flags", {13'd0, flags}, 16'h0004);

        issue(16'h0000, 16'h7FF0, 16'h0020, 16'h0000, 1'b0);
        issue(16'h2000, 16'h1234, 16'h1234, 16'h0000, 1'b0);
        chk("xor_zero", xm_result, 16'h0000);
        chk("xor_flags", {13'd0, flags}, 16'h0006);

        MemRead = 1'b1;
        instruction = 16'h8000;
        a = 16'h1001;
        imm = 16'h0004;
        ALUsrc = 1'b1;
        MemtoReg = 1'b1;
        @(posedge clk);
        #1;
        chk("lw_addr", xm_result, 16'h1004);
        chk("lw_memread", {15'd0, xm_memread_out}, 16'h0001);
        chk("lw_flags", {13'd0, flags}, 16'h0006);

        issue(16'h1000, 16'h8000, 16'h0001, 16'h0000, 1'b0);
        chk("sub_negsat", xm_result, 16'h8000);
        chk("sub_neg_flags", {13'd0, flags}, 16'h0003);

        issue(16'h5004, 16'h8F00, 16'h0000, 16'h0000, 1'b0);
        chk("sra4", xm_result, 16'hF8F0);
        chk("sra_flags", {13'd0, flags}, 16'h0003);
        issue(16'h6008, 16'h1234, 16'h0000, 16'h0000, 1'b0);
        chk("ror8", xm_result, 16'h3412);
        issue(16'h4000, 16'hABCD, 16'h0000, 16'h0000, 1'b0);
        chk("sll0", xm_result, 16'hABCD);
        issue(16'h4003, 16'h0011, 16'h0000, 16'h0000, 1'b0);
        chk("sll3", xm_result, 16'h0088);
        issue(16'h3000, 16'h7F80, 16'h0102, 16'h0000, 1'b0);
        chk("red", xm_result, 16'h0002);
        issue(16'h3000, 16'h8080, 16'h8080, 16'h0000, 1'b0);
        chk("red_neg", xm_result, 16'hFE00);
        issue(16'h7000, 16'h7788, 16'h1111, 16'h0000, 1'b0);
        chk("paddsb", xm_result, 16'h7799);
        chk("red_pad_flags", {13'd0, flags}, 16'h0003);
        issue(16'hA000, 16'hABCD, 16'h0000, 16'h0012, 1'b1);
        chk("llb", xm_result, 16'hAB12);
        issue(16'hB000, 16'hABCD, 16'h0000, 16'h0012, 1'b1);
        chk("lhb", xm_result, 16'h12CD);
        newPC = 16'h0042;
        issue(16'hE000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        chk("pcs", xm_result, 16'h0042);
        issue(16'h2000, 16'hFFFF, 16'h0F0F, 16'h0000, 1'b0);
        chk("xor_nz", xm_result, 16'hF0F0);
        chk("xor_nz_flags", {13'd0, flags}, 16'h0003);

        Source1 = 4'd3;
        mem_fwd_we = 1'b1;
        mem_fwd_reg = 4'd3;
        mem_fwd_data = 16'h1111;
        wb_fwd_we = 1'b1;
        wb_fwd_reg = 4'd3;
        wb_fwd_data = 16'h2222;
        issue(16'h0000, 16'h0000, 16'h0001, 16'h0000, 1'b0);
        chk("fwd_mem", xm_result, fwd_exp1);
        chk("fwd_flags", {13'd0, flags}, 16'h0000);
        mem_fwd_we = 1'b0;
        issue(16'h0000, 16'h0000, 16'h0001, 16'h0000, 1'b0);
        chk("fwd_wb", xm_result, fwd_exp2);
        mem_fwd_we = 1'b1;
        Source1 = 4'd0;
        mem_fwd_reg = 4'd0;
        wb_fwd_reg = 4'd0;
        issue(16'h0000, 16'h0000, 16'h0001, 16'h0000, 1'b0);
        chk("fwd_r0", xm_result, 16'h0001);
        mem_fwd_we = 1'b0;
        wb_fwd_we = 1'b0;

        issue(16'h1000, 16'h8000, 16'h0001, 16'h0000, 1'b0);
        chk("pre_stall", xm_result, 16'h8000);
        for (int i = 0; i < 3; i++) begin
            wen = 1'b0;
            flush = (i == 1);
            instruction = 16'h0000;
            a = 16'h1000 + 16'(i);
            b = 16'h0000;
            @(posedge clk);
            #1;
            chk("stall_result", xm_result, 16'h8000);
            chk("stall_flags", {13'd0, flags}, 16'h0003);
        end

        wen = 1'b1;
        flush = 1'b1;
        instruction = 16'h0000;
        a = 16'h7FF0;
        b = 16'h0020;
        @(posedge clk);
        #1;
        chk("flush_result", xm_result, 16'h0000);
        chk("flush_rw", {15'd0, xm_regwrite_out}, 16'h0000);
        chk("flush_inst", xm_inst, 16'h0000);
        chk("flush_flags", {13'd0, flags}, 16'h0003);

        flush = 1'b0;
        RegWrite = 1'b0;
        halt = 1'b1;
        instruction = 16'hF000;
        @(posedge clk);
        #1;
        chk("hlt_halt", {15'd0, xm_halt_out}, 16'h0001);
        chk("hlt_result", xm_result, 16'h0000);
        halt = 1'b0;
        MemWrite = 1'b1;
        ALUsrc = 1'b1;
        instruction = 16'h9000;
        a = 16'h0010;
        imm = 16'h0002;
        @(posedge clk);
        #1;
        chk("sw_halt", {15'd0, xm_halt_out}, 16'h0001);
        chk("sw_memwr", {15'd0, xm_memwrite_out}, 16'h0000);
        MemWrite = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_halt", {15'd0, xm_halt_out}, 16'h0000);

        issue(16'h0000, 16'h7FF0, 16'h0020, 16'h0000, 1'b0);
        chk("pre_rst_flags", {13'd0, flags}, 16'h0002);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_flags", {13'd0, flags}, 16'h0000);
        chk("rst_result", xm_result, 16'h0000);
        chk("rst_rw", {15'd0, xm_regwrite_out}, 16'h0000);
        chk("rst_inst", xm_inst, 16'h0000);
        #1;
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
